dmem_bridge: RTL
================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of REQ-state cycles to wait for bus_ack before aborting.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: value returned on readdatam after a timed-out access.
REQ-003 The block SHALL have one clock, clk; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock shared with the pipelined processor.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 memreadm  input  1  M-stage load request (memtoregm from the processor).
REQ-007 memwritem  input  1  M-stage store request.
REQ-008 aluoutm  input  32  M-stage byte address.
REQ-009 writedatam  input  32  M-stage store data.
REQ-010 readdatam  output  32  load data returned to the processor's W-stage register.
REQ-011 stallm  output  1  freeze request to the hazard unit; all pipeline stages hold while it is high.
REQ-012 bus_req  output  1  external memory request.
REQ-013 bus_we  output  1  1 = write, 0 = read.
REQ-014 bus_addr  output  32  word address {aluoutm[31:2],2'b00}.
REQ-015 bus_wdata  output  32  store data.
REQ-016 bus_ack  input  1  one-cycle completion strobe from memory.
REQ-017 bus_rdata  input  32  read data, valid in the bus_ack cycle.
REQ-018 err  output  1  sticky error flag.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-020 In IDLE with access = memreadm|memwritem high, the block SHALL drive stallm=1 combinationally, register bus_addr, bus_wdata and bus_we (=memwritem), and go to REQ on the next edge.
REQ-021 In IDLE with access low, stallm SHALL be 0 and the state SHALL remain IDLE.
REQ-022 In REQ, bus_req and stallm SHALL be 1, and bus_addr, bus_we and bus_wdata SHALL stay constant until the state is left.
REQ-023 In REQ with bus_ack=1, the block SHALL capture bus_rdata into readdatam (reads only; writes leave readdatam unchanged), deassert bus_req on the next edge, and go to DONE.
REQ-024 In DONE, stallm SHALL be 0 so the pipeline advances on that edge, readdatam SHALL hold its value, and the next state SHALL be IDLE unconditionally.
REQ-025 Because of DONE, a given access SHALL never be issued twice; back-to-back accesses start one cycle after DONE.
REQ-026 Minimum stall is 2 cycles (access with bus_ack in the first REQ cycle); stall length = 2 + the number of REQ cycles before bus_ack.
REQ-027 A cycle counter SHALL clear on entry to REQ and increment each REQ cycle.
REQ-028 If the counter reaches TIMEOUT with bus_ack low, the block SHALL drop bus_req, load readdatam=ERR_DATA, set err, and go to DONE.
REQ-029 bus_ack outside REQ SHALL be ignored, including any ack arriving in the cycle after a timeout abort.
REQ-030 If memreadm and memwritem are both 1, the access SHALL be performed as a write and err SHALL be set.
REQ-031 If aluoutm[1:0]!=0, the access SHALL proceed at the aligned address and err SHALL be set.
REQ-032 Once set, err SHALL remain 1 until reset.
REQ-033 Input changes while in REQ or DONE SHALL not affect the in-flight transaction.

Reset
REQ-034 While reset=0, the block SHALL force: state=IDLE, stallm=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, readdatam=0, err=0, counter=0.
REQ-035 Reset asserted mid-transaction SHALL abort immediately, with bus_req=0 in the same cycle.
REQ-036 After reset is released, the first access SHALL start from IDLE.

Verification
REQ-037 Load, aluoutm=0x40, bus_ack in the 1st REQ cycle with bus_rdata=0x12345678 -> stallm high for 2 cycles; readdatam=0x12345678 in DONE; bus_we=0, bus_addr=0x40.
REQ-038 Store, aluoutm=0x80, writedatam=0xCAFEF00D, bus_ack after 3 REQ cycles -> bus_we=1, bus_wdata constant throughout; stall 5 cycles; readdatam unchanged.
REQ-039 Load with no bus_ack, TIMEOUT=4 -> bus_req drops after 4 REQ cycles; readdatam=0xDEADBEEF; err=1; late bus_ack ignored.
REQ-040 Two consecutive loads (0x10, then 0x14) -> two distinct bus_req episodes separated by DONE and IDLE; each address issued exactly once.
REQ-041 aluoutm=0x43 with memreadm=1 -> bus_addr=0x40; err=1 and stays 1 through later clean accesses.
REQ-042 reset=0 asserted during REQ -> bus_req and stallm 0 immediately; all outputs 0; after release the next load completes normally.

Source files
------------

// File: rtl/dmem_bridge_if.sv
// rtl/dmem_bridge_if.sv - external memory bus between the data-memory bridge and the memory
interface dmem_bridge_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_wdata,
      input  bus_ack,
      input  bus_rdata
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_wdata,
      output bus_ack,
      output bus_rdata
   );
endinterface

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - stalls the M stage while a load/store runs on a slow ack-based memory bus
module dmem_bridge #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               memreadm,
   input  logic               memwritem,
   input  logic [31:0]        aluoutm,
   input  logic [31:0]        writedatam,
   output logic [31:0]        readdatam,
   output logic               stallm,
   output logic               err,
   dmem_bridge_if.master      bus
);

   // Wide enough to hold TIMEOUT itself, since the counter steps onto it in the abort cycle.
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          access;
   logic          ack_hit;
   logic          timed_out;
   logic          issue;

   assign access = memreadm | memwritem;
   assign issue  = (state == IDLE) && access;

   // Next state, stall and bus request; DONE exists so the released pipeline never re-issues.
   always_comb begin
      state_nxt    = state;
      stallm       = 1'b0;
      bus.bus_req  = 1'b0;
      ack_hit      = 1'b0;
      timed_out    = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               stallm    = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            stallm      = 1'b1;
            bus.bus_req = 1'b1;
            if (bus.bus_ack) begin
               ack_hit   = 1'b1;
               state_nxt = DONE;
            end else if (cnt == CNT_LAST) begin
               timed_out = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // Reset held low must not freeze the pipeline even if an access is presented.
      if (!reset) begin
         stallm      = 1'b0;
         bus.bus_req = 1'b0;
      end
   end

   // State register; asynchronous reset aborts any in-flight access at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Request fields are latched once at issue and held until the next issue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.bus_addr  <= 32'h0;
         bus.bus_wdata <= 32'h0;
         bus.bus_we    <= 1'b0;
      end else if (issue) begin
         bus.bus_addr  <= {aluoutm[31:2], 2'b00};
         bus.bus_wdata <= writedatam;
         bus.bus_we    <= memwritem;
      end
   end

   // Wait counter: cleared when entering REQ, counts every REQ cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (issue) begin
         cnt <= '0;
      end else if (state == REQ) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Load data: bus data on a read ack, the error pattern on abort, otherwise held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readdatam <= 32'h0;
      end else if (timed_out) begin
         readdatam <= ERR_DATA;
      end else if (ack_hit && !bus.bus_we) begin
         readdatam <= bus.bus_rdata;
      end
   end

   // Sticky error: conflicting read+write, misaligned address, or bus timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (timed_out ||
                   (issue && ((memreadm && memwritem) || (aluoutm[1:0] != 2'b00)))) begin
         err <= 1'b1;
      end
   end

endmodule
